des_perm_pipe: RTL and testbench

- Parametrised, pipelined, multi-mode DES bit-permutation unit with valid/ready handshake.
- Performs any of the following on each input word: E expansion, E expansion XOR round subkey, P permutation, IP, or FP.
- Sits between the DES key schedule/S-box datapath and the 3DES round controller, so one shared instance serves every fixed DES permutation.

---
 rtl/des_perm_pipe.sv | 148 ++++++++++++++
 tb/tb_des_perm_pipe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/des_perm_pipe.sv
// Pipelined DES permutation unit: E, E^K, P, IP and FP on one valid/ready datapath.
// The permutation is combinational on the stage-1 input, and the later stages only delay it.
module des_perm_pipe #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_mode,
  input  logic [63:0]      in_data,
  input  logic [47:0]      in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             out_err,
  output logic [CNT_W-1:0] xfer_count
);

  if ((STAGES == 0) || (STAGES > 4)) begin : gen_stages_check
    $error("des_perm_pipe: STAGES must be in 1..4");
  end

  localparam int NumStages = int'(STAGES);

  typedef enum logic [2:0] {
    ModeE   = 3'd0,
    ModeEk  = 3'd1,
    ModeP   = 3'd2,
    ModeIp  = 3'd3,
    ModeFp  = 3'd4
  } mode_e;

  // Tables use DES numbering: entry i names the 1-based source bit, and bit 1 is the MSB.
  localparam int IpTab [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7
  };

  localparam int FpTab [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32,
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25
  };

  localparam int PTab [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  logic        advance;
  logic [31:0] r_half;
  logic [47:0] e_res;
  logic [31:0] p_res;
  logic [63:0] ip_res;
  logic [63:0] fp_res;
  logic [63:0] perm_res;
  logic        perm_err;

  logic             stage_valid_q [NumStages];
  logic [63:0]      stage_data_q  [NumStages];
  logic             stage_err_q   [NumStages];
  logic [CNT_W-1:0] xfer_count_q;

  assign r_half = in_data[31:0];

  // Vector bit (W-1-i) holds DES bit i, so every tap below is mirrored.
  for (genvar g = 0; g < 8; g++) begin : gen_e_group
    for (genvar j = 0; j < 6; j++) begin : gen_e_bit
      localparam int Src = (4 * g + 31 + j) % 32;
      assign e_res[47 - (6 * g + j)] = r_half[31 - Src];
    end
  end

  for (genvar i = 0; i < 32; i++) begin : gen_p
    assign p_res[31 - i] = r_half[32 - PTab[i]];
  end

  for (genvar i = 0; i < 64; i++) begin : gen_ip_fp
    assign ip_res[63 - i] = in_data[64 - IpTab[i]];
    assign fp_res[63 - i] = in_data[64 - FpTab[i]];
  end

  always_comb begin
    perm_res = '0;
    perm_err = 1'b0;
    case (in_mode)
      ModeE:   perm_res = {e_res, 16'h0000};
      ModeEk:  perm_res = {e_res ^ in_key, 16'h0000};
      ModeP:   perm_res = {32'h0000_0000, p_res};
      ModeIp:  perm_res = ip_res;
      ModeFp:  perm_res = fp_res;
      default: perm_err = 1'b1;
    endcase
  end

  // Every stage moves together, and empty slots are not collapsed, so out_valid
  // alone decides whether a stall occurs.
  assign out_valid = stage_valid_q[NumStages-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NumStages; k++) begin
        stage_valid_q[k] <= 1'b0;
        stage_data_q[k]  <= '0;
        stage_err_q[k]   <= 1'b0;
      end
    end else if (advance) begin
      stage_valid_q[0] <= in_valid;
      stage_data_q[0]  <= perm_res;
      stage_err_q[0]   <= perm_err;
      for (int k = 1; k < NumStages; k++) begin
        stage_valid_q[k] <= stage_valid_q[k-1];
        stage_data_q[k]  <= stage_data_q[k-1];
        stage_err_q[k]   <= stage_err_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_count_q <= '0;
    end else if (out_valid && out_ready) begin
      xfer_count_q <= xfer_count_q + 1'b1;
    end
  end

  assign out_data   = stage_data_q[NumStages-1];
  assign out_err    = stage_err_q[NumStages-1];
  assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_des_perm_pipe.sv
// Scoreboard bench for des_perm_pipe (STAGES=2, CNT_W=4) using hand-computed DES vectors.
module tb_des_perm_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_mode;
  logic [63:0] in_data;
  logic [47:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_err;
  logic [3:0]  xfer_count;

  always #5 clk = ~clk;

  des_perm_pipe #(
    .STAGES(2),
    .CNT_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .xfer_count(xfer_count)
  );

  typedef struct packed {
    logic [2:0]  mode;
    logic [63:0] data;
    logic [47:0] key;
    logic [63:0] exp;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic [63:0] d;
    logic        e;
  } exp_t;

  localparam int NumVecs = 12;

  vec_t       vecs [NumVecs];
  exp_t       sb [$];
  int         checks = 0;
  int         failures = 0;
  int         stall_cycles = 0;
  logic [3:0] exp_cnt = 4'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: an output transfer at the coming edge is decided by levels seen at the negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        exp_cnt = 4'd0;
      end else begin
        check("xfer_count", 64'(xfer_count), 64'(exp_cnt));
        check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
        if (!in_ready) stall_cycles++;
        if (out_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_out", 64'(out_valid), 64'd0);
          end else begin
            check("out_data", out_data, sb[0].d);
            check("out_err", 64'(out_err), 64'(sb[0].e));
            if (out_ready) begin
              void'(sb.pop_front());
              exp_cnt = exp_cnt + 4'd1;
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send(input vec_t v);
    int   n = 0;
    exp_t e;
    in_valid = 1'b1;
    in_mode  = v.mode;
    in_data  = v.data;
    in_key   = v.key;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      check("send_accept", 64'(in_ready), 64'd1);
    end else begin
      e.d = v.exp;
      e.e = v.err;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 64'(sb.size() == 0 && !out_valid), 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int  lat;
    logic saw;
    vecs[0]  = '{3'd0, 64'h0000_0000_0000_0001, 48'h0, 64'h8000_0000_0002_0000, 1'b0};
    vecs[1]  = '{3'd0, 64'h0000_0000_8000_0000, 48'h0, 64'h4000_0000_0001_0000, 1'b0};
    vecs[2]  = '{3'd1, 64'h0, 48'hFFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_0000, 1'b0};
    vecs[3]  = '{3'd2, 64'h0000_0000_0001_0000, 48'h0, 64'h0000_0000_8000_0000, 1'b0};
    vecs[4]  = '{3'd3, 64'h0123_4567_89AB_CDEF, 48'h0, 64'hCC00_CCFF_F0AA_F0AA, 1'b0};
    vecs[5]  = '{3'd4, 64'hCC00_CCFF_F0AA_F0AA, 48'h0, 64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[6]  = '{3'd6, 64'hDEAD_BEEF_0123_4567, 48'h0, 64'h0, 1'b1};
    vecs[7]  = '{3'd0, 64'hFFFF_FFFF_0000_0001, 48'h0, 64'h8000_0000_0002_0000, 1'b0};
    vecs[8]  = '{3'd1, 64'h0000_0000_0000_0001, 48'h8000_0000_0000,
                 64'h0000_0000_0002_0000, 1'b0};
    vecs[9]  = '{3'd2, 64'hFFFF_FFFF_8000_0000, 48'h0, 64'h0000_0000_0080_0000, 1'b0};
    vecs[10] = '{3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 64'h0, 1'b1};
    vecs[11] = '{3'd7, 64'h0000_0000_0000_0001, 48'h0, 64'h0, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 3'd0;
    in_data   = 64'h0;
    in_key    = 48'h0;
    out_ready = 1'b1;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", out_data, 64'h0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_xfer_count", 64'(xfer_count), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First word: out_valid must appear two cycles after the accept cycle.
    @(posedge clk);
    #1;
    send(vecs[0]);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'd2);
    wait_drain();
    check("first_xfer_count", 64'(xfer_count), 64'd1);

    // All directed vectors back to back.
    for (int i = 1; i < NumVecs; i++) send(vecs[i]);
    wait_drain();

    // Backpressure: out_ready low for three cycles while the stream is flowing.
    do_reset();
    stall_cycles = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(vecs[i]);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check("stall_cycles", 64'(stall_cycles), 64'd3);
    check("bp_xfer_count", 64'(xfer_count), 64'd6);

    // Reset with two words in flight.
    do_reset();
    send(vecs[4]);
    send(vecs[5]);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_xfer_count", 64'(xfer_count), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) saw = 1'b1;
    end
    check("no_stale_after_rst", 64'(saw), 64'd0);

    // Counter wrap with CNT_W=4.
    do_reset();
    repeat (17) send(vecs[0]);
    wait_drain();
    check("wrap_xfer_count", 64'(xfer_count), 64'd1);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
